hermes_task_ejector: RTL and testbench
======================================

// Module: hermes_task_ejector
// PURPOSE
//  Receiving end of the task-injection path. Sits on a boundary router port of the many-core mesh.
//  Accepts Hermes packets (flit0 = header, flit1 = payload size N, then N payload flits) from the
//  NoC via the rx/credit interface, buffers them, strips header and size, and streams the payload
//  to an off-chip sink over an equal rx/credit link, with start/end-of-packet marks.
// PARAMETERS
//  FLIT_SIZE     32  flit/data width in bits
//  BUFFER_DEPTH  8   input FIFO entries; power of 2, >= 2
// PORTS
//  clk_i         in   1          clock, all state on rising edge
//  rst_i         in   1          asynchronous reset, active-high
//  noc_rx_i      in   1          flit valid from router port
//  noc_credit_o  out  1          ready to accept a NoC flit (FIFO not full)
//  noc_data_i    in   FLIT_SIZE  flit from router
//  sink_tx_o     out  1          payload flit valid toward sink
//  sink_credit_i in   1          sink accepts flit this cycle
//  sink_data_o   out  FLIT_SIZE  payload flit
//  sink_sop_o    out  1          first payload flit of packet (qualified by sink_tx_o)
//  sink_eop_o    out  1          last payload flit of packet (qualified by sink_tx_o)
//  pkt_header_o  out  FLIT_SIZE  header of packet in flight; held until next header is popped
// BEHAVIOUR
//  - Reset (async, rst_i=1): FIFO emptied, FSM=WAIT_HDR, remaining=0.
//    noc_credit_o=1 after release. sink_tx_o, sink_sop_o and sink_eop_o are 0. pkt_header_o and
//    sink_data_o are 0. A packet in flight is discarded. No partial output after reset.
//  - NoC side: push when noc_rx_i && noc_credit_o. noc_credit_o = !full, driven from a register
//    with no combinational path from sink_credit_i.
//  - FIFO: registered storage. Push and pop in the same cycle are legal at any occupancy except
//    push-when-full, which the credit prevents. Pointers wrap modulo BUFFER_DEPTH.
//  - Latency: a payload flit accepted at cycle N is visible on sink_data_o at N+1 at the earliest.
//  - FSM (reads FIFO head):
//    WAIT_HDR  : if !empty, pop. header -> pkt_header_o. Go WAIT_SIZE. sink_tx_o=0.
//    WAIT_SIZE : if !empty, pop. remaining <= head.
//                head==0 -> WAIT_HDR (no sink traffic). Else -> PAYLOAD, first <= 1.
//    PAYLOAD   : sink_tx_o = !empty, sink_data_o = head, sink_sop_o = first.
//                sink_eop_o = (remaining==1).
//                On sink_tx_o && sink_credit_i: pop, remaining--, first <= 0.
//                If remaining was 1 -> WAIT_HDR.
//  - sink_credit_i high while sink_tx_o is low has no effect.
//    sink_data_o is stable while sink_tx_o && !sink_credit_i.
//  - N=1: sink_sop_o and sink_eop_o are high on the same flit.
//  - Back-to-back packets: header of packet k+1 is popped the cycle after the eop pop of packet k.
//    Steady state is one payload flit per cycle, with 2 bubble cycles per packet (header and size).
//  - remaining is FLIT_SIZE wide; the size flit is taken unsigned, with no saturation.
// CONFIGURATION
//  EJECTOR_STATS_EN defined:
//    - Adds output pkt_count_o [31:0], reset 0.
//    - +1 on each completed packet: the eop pop, or a size==0 pop in WAIT_SIZE.
//    - Wraps 0xFFFFFFFF -> 0.
//  Not defined: the port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  - HermesPkg gains ejector_state_e {EJ_WAIT_HDR, EJ_WAIT_SIZE, EJ_PAYLOAD}. No other new
//    shared types.
//  - One sub-module, hermes_eject_fifo (params FLIT_SIZE, BUFFER_DEPTH).
//    Ports: push/data_in/full, pop/data_out/empty.
//  - The FSM and counters live in the top.
// TESTING
//  1. Reset then idle: sink_tx_o=0, noc_credit_o=1, pkt_header_o=0 for 20 cycles.
//  2. Packet {0x0000_0102, 3, A1,A2,A3}, sink_credit_i=1:
//     A1 has sop=1; A3 has eop=1; pkt_header_o=0x0000_0102; 3 sink transfers, in order.
//  3. Size-0 packet {0x0000_0000, 0} followed by {0x0001_0000, 1, B1}:
//     only B1 is emitted, with sop=eop=1. With EJECTOR_STATS_EN, pkt_count_o=2.
//  4. sink_credit_i=0 while a 20-flit packet streams in:
//     noc_credit_o falls after BUFFER_DEPTH (8) accepted flits. No flit is lost.
//     Releasing credit drains in order.
//  5. Alternate sink_credit_i 1/0 every cycle, two back-to-back 4-flit packets:
//     data stays stable while stalled; eop and sop fall on the correct flits.
//  6. Assert rst_i mid-payload (after 2 of 5 flits): outputs clear asynchronously.
//     Next packet {0x0202, 1, C1} emits only C1.

Source files
------------

// File: rtl/hermes_pkg.sv
// rtl/hermes_pkg.sv - shared Hermes NoC types
package hermes_pkg;

    // Packet ejector FSM states
    typedef enum logic [1:0] {
        EJ_WAIT_HDR  = 2'd0,
        EJ_WAIT_SIZE = 2'd1,
        EJ_PAYLOAD   = 2'd2
    } ejector_state_e;

endpackage

// File: rtl/hermes_eject_fifo.sv
// rtl/hermes_eject_fifo.sv - registered flit FIFO feeding the task ejector
module hermes_eject_fifo #(
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [FLIT_SIZE-1:0] data_in,
    output logic                 full,
    input  logic                 pop,
    output logic [FLIT_SIZE-1:0] data_out,
    output logic                 empty
);

    localparam int AW = $clog2(BUFFER_DEPTH);

    logic [FLIT_SIZE-1:0] mem [BUFFER_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 do_push;
    logic                 do_pop;

    // Full/empty decode only registered occupancy, so upstream credit never
    // sees a combinational path from the consumer side.
    assign full     = (count == (AW+1)'(BUFFER_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // Storage write; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hermes_task_ejector.sv
// rtl/hermes_task_ejector.sv - strips Hermes header/size and streams payload to sink (option: EJECTOR_STATS_EN)
module hermes_task_ejector
    import hermes_pkg::*;
#(
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 noc_rx_i,
    output logic                 noc_credit_o,
    input  logic [FLIT_SIZE-1:0] noc_data_i,
    output logic                 sink_tx_o,
    input  logic                 sink_credit_i,
    output logic [FLIT_SIZE-1:0] sink_data_o,
    output logic                 sink_sop_o,
    output logic                 sink_eop_o,
    output logic [FLIT_SIZE-1:0] pkt_header_o
`ifdef EJECTOR_STATS_EN
    ,
    output logic [31:0]          pkt_count_o
`endif
);

    ejector_state_e       state;
    ejector_state_e       state_n;
    logic [FLIT_SIZE-1:0] remaining;
    logic [FLIT_SIZE-1:0] header_q;
    logic                 first;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [FLIT_SIZE-1:0] fifo_head;
    logic                 sink_tx;

    hermes_eject_fifo #(
        .FLIT_SIZE    (FLIT_SIZE),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (noc_rx_i),
        .data_in  (noc_data_i),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .data_out (fifo_head),
        .empty    (fifo_empty)
    );

    assign noc_credit_o = !fifo_full;
    assign sink_tx_o    = sink_tx;
    assign sink_data_o  = sink_tx ? fifo_head : '0;
    assign sink_sop_o   = sink_tx && first;
    assign sink_eop_o   = sink_tx && (remaining == FLIT_SIZE'(1));
    assign pkt_header_o = header_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EJ_WAIT_HDR;
        end else begin
            state <= state_n;
        end
    end

    // Next state, FIFO pop and sink valid from the FIFO head
    always_comb begin
        state_n  = state;
        fifo_pop = 1'b0;
        sink_tx  = 1'b0;
        case (state)
            EJ_WAIT_HDR: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_n  = EJ_WAIT_SIZE;
                end
            end
            EJ_WAIT_SIZE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_n  = (fifo_head == '0) ? EJ_WAIT_HDR : EJ_PAYLOAD;
                end
            end
            EJ_PAYLOAD: begin
                sink_tx = !fifo_empty;
                if (sink_tx && sink_credit_i) begin
                    fifo_pop = 1'b1;
                    if (remaining == FLIT_SIZE'(1)) begin
                        state_n = EJ_WAIT_HDR;
                    end
                end
            end
            default: state_n = EJ_WAIT_HDR;
        endcase
    end

    // Header capture, payload countdown and start-of-packet flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            header_q  <= '0;
            remaining <= '0;
            first     <= 1'b0;
        end else if (fifo_pop) begin
            case (state)
                EJ_WAIT_HDR: header_q <= fifo_head;
                EJ_WAIT_SIZE: begin
                    remaining <= fifo_head;
                    first     <= 1'b1;
                end
                EJ_PAYLOAD: begin
                    remaining <= remaining - FLIT_SIZE'(1);
                    first     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef EJECTOR_STATS_EN
    logic        pkt_done;
    logic [31:0] pkt_count;

    // A packet completes on its eop pop, or on an empty-size pop
    assign pkt_done = fifo_pop &&
                      (((state == EJ_WAIT_SIZE) && (fifo_head == '0)) ||
                       ((state == EJ_PAYLOAD) && (remaining == FLIT_SIZE'(1))));
    assign pkt_count_o = pkt_count;

    // Completed-packet counter, wrapping freely
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_count <= '0;
        end else if (pkt_done) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hermes_task_ejector.sv
// tb/tb_hermes_task_ejector.sv - directed self-checking bench for hermes_task_ejector
module tb_hermes_task_ejector;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        noc_rx_i = 1'b0;
    logic        noc_credit_o;
    logic [31:0] noc_data_i = '0;
    logic        sink_tx_o;
    logic        sink_credit_i = 1'b1;
    logic [31:0] sink_data_o;
    logic        sink_sop_o;
    logic        sink_eop_o;
    logic [31:0] pkt_header_o;
`ifdef EJECTOR_STATS_EN
    logic [31:0] pkt_count_o;
`endif

    int errors = 0;
    int checks = 0;
    logic        toggle_mode = 1'b0;
    logic [33:0] cap_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    hermes_task_ejector #(
        .FLIT_SIZE    (32),
        .BUFFER_DEPTH (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .noc_rx_i      (noc_rx_i),
        .noc_credit_o  (noc_credit_o),
        .noc_data_i    (noc_data_i),
        .sink_tx_o     (sink_tx_o),
        .sink_credit_i (sink_credit_i),
        .sink_data_o   (sink_data_o),
        .sink_sop_o    (sink_sop_o),
        .sink_eop_o    (sink_eop_o),
        .pkt_header_o  (pkt_header_o)
`ifdef EJECTOR_STATS_EN
        ,
        .pkt_count_o   (pkt_count_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Alternating sink credit when enabled
    always @(negedge clk) begin
        if (toggle_mode) sink_credit_i = ~sink_credit_i;
    end

    // Sink monitor: records transfers and checks stall stability
    always begin
        @(negedge clk);
        #2;
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_tx_held", {31'd0, sink_tx_o}, 32'd1);
                check("stall_data_held", sink_data_o, prev_data);
            end
            if (sink_tx_o && sink_credit_i)
                cap_q.push_back({sink_data_o, sink_sop_o, sink_eop_o});
            prev_stall = sink_tx_o && !sink_credit_i;
            prev_data  = sink_data_o;
        end
    end

    task automatic push(input logic [31:0] d);
        int t = 0;
        noc_rx_i   = 1'b1;
        noc_data_i = d;
        while (!noc_credit_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("push_timeout", 32'd1, 32'd0);
        @(negedge clk);
        noc_rx_i = 1'b0;
    endtask

    task automatic wait_cap(input string tag, input int n);
        int t = 0;
        while (cap_q.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_timeout"}, {31'd0, t >= 500}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_cap(input string tag, input logic [31:0] exp_d[$], input int len);
        check({tag, "_count"}, cap_q.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < cap_q.size()) begin
                check({tag, "_data"}, cap_q[i][33:2], exp_d[i]);
                check({tag, "_sop"}, {31'd0, cap_q[i][1]}, {31'd0, (i % len) == 0});
                check({tag, "_eop"}, {31'd0, cap_q[i][0]}, {31'd0, (i % len) == len - 1});
            end
        end
        cap_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_d[$];

        // 1. reset and idle
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("idle_tx", {31'd0, sink_tx_o}, 32'd0);
            check("idle_credit", {31'd0, noc_credit_o}, 32'd1);
            check("idle_header", pkt_header_o, 32'd0);
        end
        check("idle_data", sink_data_o, 32'd0);
`ifdef EJECTOR_STATS_EN
        check("idle_count", pkt_count_o, 32'd0);
`endif

        // 2. simple 3-flit packet
        @(negedge clk);
        push(32'h0000_0102); push(32'd3);
        push(32'hA1); push(32'hA2); push(32'hA3);
        wait_cap("p2", 3);
        exp_d = '{32'hA1, 32'hA2, 32'hA3};
        check_cap("p2", exp_d, 3);
        check("p2_header", pkt_header_o, 32'h0000_0102);

        // 3. size-0 packet then 1-flit packet
        do_reset();
        push(32'h0000_0000); push(32'd0);
        push(32'h0001_0000); push(32'd1); push(32'hB1);
        wait_cap("p3", 1);
        exp_d = '{32'hB1};
        check_cap("p3", exp_d, 1);
        check("p3_header", pkt_header_o, 32'h0001_0000);
`ifdef EJECTOR_STATS_EN
        check("p3_count", pkt_count_o, 32'd2);
`endif

        // 4. backpressure: FIFO fills after 8 payload flits
        sink_credit_i = 1'b0;
        push(32'h0000_0404); push(32'd20);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("p4_credit_open", {31'd0, noc_credit_o}, 32'd1);
            push(32'h4000 + i);
        end
        #1;
        check("p4_credit_closed", {31'd0, noc_credit_o}, 32'd0);
        check("p4_no_transfer", cap_q.size(), 32'd0);
        @(negedge clk);
        sink_credit_i = 1'b1;
        for (int i = 8; i < 20; i++) push(32'h4000 + i);
        wait_cap("p4", 20);
        exp_d.delete();
        for (int i = 0; i < 20; i++) exp_d.push_back(32'h4000 + i);
        check_cap("p4", exp_d, 20);

        // 5. alternating credit, two back-to-back 4-flit packets
        toggle_mode = 1'b1;
        push(32'h0000_0505); push(32'd4);
        push(32'hD1); push(32'hD2); push(32'hD3); push(32'hD4);
        push(32'h0000_0506); push(32'd4);
        push(32'hE1); push(32'hE2); push(32'hE3); push(32'hE4);
        wait_cap("p5", 8);
        toggle_mode   = 1'b0;
        sink_credit_i = 1'b1;
        exp_d = '{32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hE1, 32'hE2, 32'hE3, 32'hE4};
        check_cap("p5", exp_d, 4);
        check("p5_header", pkt_header_o, 32'h0000_0506);
`ifdef EJECTOR_STATS_EN
        check("p5_count", pkt_count_o, 32'd5);
`endif

        // 6. reset mid-payload
        @(negedge clk);
        sink_credit_i = 1'b0;
        push(32'h0000_0303); push(32'd5);
        push(32'hF1); push(32'hF2); push(32'hF3); push(32'hF4); push(32'hF5);
        sink_credit_i = 1'b1;
        repeat (2) @(negedge clk);
        sink_credit_i = 1'b0;
        #3;
        exp_d = '{32'hF1, 32'hF2};
        check_cap("p6_pre", exp_d, 5);
        @(negedge clk);
        #1;
        check("p6_tx_before", {31'd0, sink_tx_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("p6_rst_tx", {31'd0, sink_tx_o}, 32'd0);
        check("p6_rst_sop", {31'd0, sink_sop_o}, 32'd0);
        check("p6_rst_eop", {31'd0, sink_eop_o}, 32'd0);
        check("p6_rst_data", sink_data_o, 32'd0);
        check("p6_rst_header", pkt_header_o, 32'd0);
        check("p6_rst_credit", {31'd0, noc_credit_o}, 32'd1);
        @(negedge clk);
        rst_i = 1'b0;
        sink_credit_i = 1'b1;
        push(32'h0000_0202); push(32'd1); push(32'hC1);
        wait_cap("p6", 1);
        exp_d = '{32'hC1};
        check_cap("p6", exp_d, 1);
        check("p6_header", pkt_header_o, 32'h0000_0202);
`ifdef EJECTOR_STATS_EN
        check("p6_count", pkt_count_o, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
